right_shift_register_array_controller: RTL and testbench

Stream controller that sequences a `right_shift_register_array` (BIT_WIDTH-wide, DEPTH-deep delay line) as a valid/ready pipeline stage. It gates the array's `enable`, tracks which stages hold live words with a DEPTH-bit tag vector, and presents the array's last stage as a backpressured output stream. It also drains the line on request by shifting bubbles. It sits between an upstream producer and a downstream consumer. The array itself is a separate instance that shares `clk`/`reset`.

---
 rtl/right_shift_register_array_controller.sv | 86 ++++++++
 tb/tb_right_shift_register_array_controller.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/right_shift_register_array_controller.sv
// Valid/ready controller for an external right_shift_register_array delay line.
// Tracks live stages with a tag vector, gates the array enable and drains the line on flush.
module right_shift_register_array_controller #(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIT_WIDTH-1:0]         in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BIT_WIDTH-1:0]         out_data,
  input  logic                         flush,
  output logic                         flush_done,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         shift_enable,
  output logic [BIT_WIDTH-1:0]         array_in,
  input  logic [BIT_WIDTH-1:0]         array_out
);

  localparam int OW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state;
  logic [DEPTH-1:0] tag;
  logic            stall;
  logic            push;
  logic            pop;
  logic [OW-1:0]   occ_next;

  // Head of the line is the last tag; a live head that is not taken blocks every shift.
  assign out_valid    = tag[DEPTH-1];
  assign out_data     = array_out;
  assign stall        = tag[DEPTH-1] & ~out_ready;
  assign in_ready     = ~stall & (state != FLUSH) & ~reset;
  assign push         = in_valid & in_ready;
  assign pop          = out_valid & out_ready;
  assign shift_enable = (push | ((state == FLUSH) & ~stall)) & ~reset;
  assign array_in     = push ? in_data : '0;
  assign occ_next     = occupancy + OW'(push) - OW'(pop);

  // A pop without a shift only retires the head tag; the stale array word stays hidden.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag        <= '0;
      occupancy  <= '0;
      state      <= IDLE;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      occupancy  <= occ_next;
      if (shift_enable) begin
        tag <= {tag[DEPTH-2:0], push};
      end else if (pop) begin
        tag[DEPTH-1] <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (push) state <= RUN;
        end
        RUN: begin
          if (flush) begin
            state <= FLUSH;
          end else if (occ_next == '0) begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          if (occ_next == '0) begin
            state      <= IDLE;
            flush_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_right_shift_register_array_controller.sv
// Bench for right_shift_register_array_controller with a behavioural array and a
// positional queue model of the words in flight.
module tb_right_shift_register_array_controller;

  localparam int BW    = 8;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH+1);

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          flush;
  logic          flush_done;
  logic [OW-1:0] occupancy;
  logic          shift_enable;
  logic [BW-1:0] array_in;
  logic [BW-1:0] array_out;

  int tests;
  int fails;

  right_shift_register_array_controller #(.BIT_WIDTH(BW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .flush(flush),
    .flush_done(flush_done),
    .occupancy(occupancy),
    .shift_enable(shift_enable),
    .array_in(array_in),
    .array_out(array_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external delay line sharing clk/reset with the controller.
  logic [DEPTH-1:0][BW-1:0] stages;
  always @(posedge clk or posedge reset) begin
    if (reset) stages <= '0;
    else if (shift_enable) stages <= {stages[DEPTH-2:0], array_in};
  end
  assign array_out = stages[DEPTH-1];

  // Reference: each accepted word with the stage index it currently occupies.
  typedef struct {
    logic [BW-1:0] data;
    int            pos;
  } ent_t;

  ent_t          line_q[$];
  bit            m_flushing;
  bit            m_fd;
  bit            m_head;
  bit            m_in_ready;
  bit            m_push;
  bit            m_shift;
  logic [BW-1:0] m_out_data;
  logic [BW-1:0] m_array_in;

  task automatic model_clear();
    line_q.delete();
    m_flushing = 0;
    m_fd       = 0;
  endtask

  task automatic model_outputs();
    bit stall;
    m_head     = (line_q.size() > 0) && (line_q[0].pos == DEPTH-1);
    m_out_data = m_head ? line_q[0].data : '0;
    stall      = m_head && !out_ready;
    m_in_ready = !stall && !m_flushing && !reset;
    m_push     = in_valid && m_in_ready;
    m_shift    = !reset && (m_push || (m_flushing && !stall));
    m_array_in = m_push ? in_data : '0;
  endtask

  task automatic tick();
    int   pre_size;
    ent_t e;
    model_outputs();
    pre_size = line_q.size();
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      if (m_head && out_ready) void'(line_q.pop_front());
      if (m_shift) begin
        foreach (line_q[i]) line_q[i].pos++;
        if (m_push) begin
          e.data = in_data;
          e.pos  = 0;
          line_q.push_back(e);
        end
      end
      m_fd = m_flushing && (line_q.size() == 0);
      if (m_flushing) m_flushing = (line_q.size() != 0);
      else            m_flushing = flush && (pre_size > 0);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    model_clear();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_word(input logic [BW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    out_ready = 1'b1;
    flush     = 1'b0;
    model_clear();
    #1;
    tests++; if (shift_enable !== 1'b0) begin fails++; $display("[TB] FAIL reset_shift_enable: got %b want 0", shift_enable); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (occupancy !== '0) begin fails++; $display("[TB] FAIL reset_occupancy: got %0d want 0", occupancy); end
    tests++; if (flush_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_flush_done: got %b want 0", flush_done); end
    tests++; if (array_in !== '0) begin fails++; $display("[TB] FAIL reset_array_in: got %h want 00", array_in); end
    tick();
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_release_in_ready: got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_fill_stream();
    logic [BW-1:0] words [4];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    out_ready = 1'b1;
    foreach (words[i]) begin
      in_valid = 1'b1;
      in_data  = words[i];
      #1;
      tests++; if (shift_enable !== 1'b1 || array_in !== words[i]) begin fails++; $display("[TB] FAIL fill_push_%0d: shift %b array_in %h want 1 %h", i, shift_enable, array_in, words[i]); end
      tick();
    end
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin fails++; $display("[TB] FAIL fill_head: valid %b data %h want 1 11", out_valid, out_data); end
    tests++; if (occupancy !== OW'(4)) begin fails++; $display("[TB] FAIL fill_occupancy: got %0d want 4", occupancy); end
    in_valid = 1'b1;
    in_data  = 8'h55;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL stream_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin fails++; $display("[TB] FAIL stream_head: valid %b data %h want 1 22", out_valid, out_data); end
    tests++; if (occupancy !== OW'(4)) begin fails++; $display("[TB] FAIL stream_occupancy: got %0d want 4", occupancy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b1;
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++; if (in_ready !== 1'b0 || shift_enable !== 1'b0) begin fails++; $display("[TB] FAIL bp_stall_c%0d: in_ready %b shift %b want 0 0", c, in_ready, shift_enable); end
      tests++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin fails++; $display("[TB] FAIL bp_hold_c%0d: valid %b data %h want 1 11", c, out_valid, out_data); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1 || shift_enable !== 1'b1 || out_data !== 8'h11) begin fails++; $display("[TB] FAIL bp_release: in_ready %b shift %b data %h want 1 1 11", in_ready, shift_enable, out_data); end
    tick();
    in_valid = 1'b0;
    tests++; if (out_data !== 8'h22 || occupancy !== OW'(4)) begin fails++; $display("[TB] FAIL bp_after: data %h occ %0d want 22 4", out_data, occupancy); end
  endtask

  task automatic test_pop_no_shift();
    do_reset();
    out_ready = 1'b1;
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    in_valid = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h11 || shift_enable !== 1'b0) begin fails++; $display("[TB] FAIL pns_first: valid %b data %h shift %b want 1 11 0", out_valid, out_data, shift_enable); end
    tick();
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++; if (out_valid !== 1'b0 || occupancy !== OW'(3) || shift_enable !== 1'b0) begin fails++; $display("[TB] FAIL pns_after_c%0d: valid %b occ %0d shift %b want 0 3 0", c, out_valid, occupancy, shift_enable); end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [BW-1:0] words [3];
    words = '{8'hA1, 8'hA2, 8'hA3};
    do_reset();
    out_ready = 1'b1;
    push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    flush = 1'b1;
    #1;
    tests++; if (shift_enable !== 1'b0) begin fails++; $display("[TB] FAIL flush_entry_shift: got %b want 0", shift_enable); end
    tick();
    flush = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b0 || shift_enable !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_bubble: in_ready %b shift %b valid %b want 0 1 0", in_ready, shift_enable, out_valid); end
    tick();
    foreach (words[i]) begin
      #1;
      tests++; if (out_valid !== 1'b1 || out_data !== words[i] || flush_done !== 1'b0) begin fails++; $display("[TB] FAIL flush_pop_%0d: valid %b data %h done %b want 1 %h 0", i, out_valid, out_data, flush_done, words[i]); end
      tick();
    end
    tests++; if (flush_done !== 1'b1 || occupancy !== '0 || in_ready !== 1'b1) begin fails++; $display("[TB] FAIL flush_done_pulse: done %b occ %0d in_ready %b want 1 0 1", flush_done, occupancy, in_ready); end
    tick();
    tests++; if (flush_done !== 1'b0) begin fails++; $display("[TB] FAIL flush_done_width: got %b want 0", flush_done); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tests++; if (flush_done !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("[TB] FAIL flush_idle_c%0d: done %b in_ready %b want 0 1", c, flush_done, in_ready); end
      tick();
    end
  endtask

  task automatic test_reset_mid_flush();
    logic [BW-1:0] words [4];
    words = '{8'h77, 8'h78, 8'h79, 8'h7A};
    do_reset();
    out_ready = 1'b0;
    push_word(8'hB1); push_word(8'hB2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b0 || occupancy !== OW'(2)) begin fails++; $display("[TB] FAIL rmf_in_flush: in_ready %b occ %0d want 0 2", in_ready, occupancy); end
    reset = 1'b1;
    model_clear();
    #1;
    tests++; if (occupancy !== '0 || out_valid !== 1'b0 || shift_enable !== 1'b0) begin fails++; $display("[TB] FAIL rmf_immediate: occ %0d valid %b shift %b want 0 0 0", occupancy, out_valid, shift_enable); end
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    foreach (words[i]) begin
      tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rmf_no_stale_%0d: valid %b data %h want 0", i, out_valid, out_data); end
      push_word(words[i]);
    end
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h77) begin fails++; $display("[TB] FAIL rmf_emerge: valid %b data %h want 1 77", out_valid, out_data); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = BW'($urandom);
      #1;
      model_outputs();
      tests++; if (in_ready !== m_in_ready || shift_enable !== m_shift) begin fails++; $display("[TB] FAIL rand_ctrl_c%0d: in_ready %b shift %b want %b %b", c, in_ready, shift_enable, m_in_ready, m_shift); end
      tests++; if (array_in !== m_array_in) begin fails++; $display("[TB] FAIL rand_array_in_c%0d: got %h want %h", c, array_in, m_array_in); end
      tests++; if (out_valid !== m_head || (m_head && out_data !== m_out_data)) begin fails++; $display("[TB] FAIL rand_out_c%0d: valid %b data %h want %b %h", c, out_valid, out_data, m_head, m_out_data); end
      tests++; if (occupancy !== OW'(line_q.size()) || flush_done !== m_fd) begin fails++; $display("[TB] FAIL rand_state_c%0d: occ %0d done %b want %0d %b", c, occupancy, flush_done, line_q.size(), m_fd); end
      tick();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b1;
    model_clear();
    @(negedge clk);
    test_reset();
    test_fill_stream();
    test_backpressure();
    test_pop_no_shift();
    test_flush();
    test_reset_mid_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
